// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_pkg
//  Purpose  : Shared constants, the flag bundle type and elaboration helpers
//             for the single-clock FIFO.
//  Contents : DEF_N, DEF_DEPTH   default data width / depth
//             fifo_flags_t        registered status flags
//             is_pow2()           DEPTH legality check
//             cnt_width()         width of the occupancy counter
//  Revision : 1.0  initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_DEPTH = 16;

  // All status flags are registered together so they always agree with
  // the registered fill count.
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // The count must represent 0..DEPTH inclusive, one bit wider than a pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_mem
//  Purpose  : Simple dual-port storage for sync_fifo: one synchronous write
//             port and one asynchronous read port. Contents are not reset.
//  Ports    : clk      clock
//             i_we     write enable
//             i_waddr  write address
//             i_wdata  write data
//             i_raddr  read address
//             o_rdata  read data (combinational from i_raddr)
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo_mem #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [N-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [N-1:0]  o_rdata
);

  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read happens before the write edge lands, so a simultaneous read and
  // write of the same slot (full FIFO) returns the old word.
  assign o_rdata = r_mem[i_raddr];

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Parametrised single-clock FIFO with occupancy count,
//             almost-full/almost-empty thresholds and sticky error flags.
//  Config   : FIFO_FWFT_EN  defined   -> first-word-fall-through read
//                           undefined -> registered read, data one cycle
//                                        after the accepted rd_en
//  Ports    : clk, rst (async, active-high)
//             wr_en/wr_data          write side
//             rd_en/rd_data/rd_valid read side
//             fifo_Full/fifo_Empty/almost_full/almost_empty  status
//             fill_count             occupancy 0..DEPTH
//             overflow/underflow     sticky errors, cleared by err_clr
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [N-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [N-1:0]             rd_data,
  output logic                     rd_valid,
  output logic                     fifo_Full,
  output logic                     fifo_Empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] c_AF_LEVEL = CW'(AF_LEVEL);
  localparam logic [CW-1:0] c_AE_LEVEL = CW'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  fifo_flags_t   r_flags;
  logic          r_ovf;
  logic          r_udf;

  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [CW-1:0] w_cnt_nxt;
  fifo_flags_t   w_flags_nxt;
  logic [N-1:0]  w_mem_rdata;

  // A full FIFO can still take a write when a read frees a slot this cycle.
  assign w_rd_acc = rd_en & ~r_flags.empty;
  assign w_wr_acc = wr_en & (~r_flags.full | w_rd_acc);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_flags_nxt        = '0;
    w_flags_nxt.full   = (w_cnt_nxt == c_DEPTH);
    w_flags_nxt.empty  = (w_cnt_nxt == '0);
    w_flags_nxt.afull  = (w_cnt_nxt >= c_AF_LEVEL);
    w_flags_nxt.aempty = (w_cnt_nxt <= c_AE_LEVEL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_flags  <= '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_cnt   <= w_cnt_nxt;
      r_flags <= w_flags_nxt;
      // A new error in the same cycle as err_clr wins over the clear.
      r_ovf   <= (wr_en & ~w_wr_acc)      | (r_ovf & ~err_clr);
      r_udf   <= (rd_en & r_flags.empty)  | (r_udf & ~err_clr);
    end
  end

  sync_fifo_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so the output
  // never exposes stale or uninitialised storage.
  assign rd_valid = ~r_flags.empty;
  assign rd_data  = r_flags.empty ? '0 : w_mem_rdata;
`else
  logic [N-1:0] r_rd_data;
  logic         r_rd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= w_mem_rdata;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
`endif

  assign fifo_Full    = r_flags.full;
  assign fifo_Empty   = r_flags.empty;
  assign almost_full  = r_flags.afull;
  assign almost_empty = r_flags.aempty;
  assign fill_count   = r_cnt;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo
//  Purpose  : Directed scoreboard bench for sync_fifo (N=8, DEPTH=16,
//             AF_LEVEL=14, AE_LEVEL=2). Works in both read modes; define
//             FIFO_FWFT_EN for the fall-through build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       fifo_Full;
  logic       fifo_Empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] fill_count;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];     // reference contents
  logic [7:0] exp_q[$];  // words the DUT still owes on its read port
  bit         m_ovf;
  bit         m_udf;
  bit         m_rvalid;  // registered-read valid expected after an edge

  sync_fifo #(
    .N        (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .fifo_Full    (fifo_Full),
    .fifo_Empty   (fifo_Empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_count   (fill_count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (!rst) begin
`ifdef FIFO_FWFT_EN
      if (rd_en && rd_valid) begin
`else
      if (rd_valid) begin
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %0h expected no word at %0t", rd_data, $time);
        end else begin
          chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic check_status();
    int n;
    n = mq.size();
    chk("fill_count", {27'd0, fill_count}, n);
    chk("fifo_Full", {31'd0, fifo_Full}, (n == 16) ? 1 : 0);
    chk("fifo_Empty", {31'd0, fifo_Empty}, (n == 0) ? 1 : 0);
    chk("almost_full", {31'd0, almost_full}, (n >= 14) ? 1 : 0);
    chk("almost_empty", {31'd0, almost_empty}, (n <= 2) ? 1 : 0);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("underflow", {31'd0, underflow}, {31'd0, m_udf});
`ifdef FIFO_FWFT_EN
    chk("rd_valid", {31'd0, rd_valid}, (n > 0) ? 1 : 0);
`else
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rvalid});
`endif
  endtask

  // One clock of stimulus; the model decides acceptance and queues the
  // word a successful read must return.
  task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit clr);
    bit ra, wa, e0;
    e0 = (mq.size() == 0);
    ra = re && !e0;
    wa = we && ((mq.size() < 16) || ra);
    wr_en = we; wr_data = wd; rd_en = re; err_clr = clr;
    if (ra) exp_q.push_back(mq.pop_front());
    if (wa) mq.push_back(wd);
    m_ovf    = (we && !wa) || (m_ovf && !clr);
    m_udf    = (re && e0) || (m_udf && !clr);
    m_rvalid = ra;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    check_status();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, 32'h0);
    chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'h0);
    chk({tag, "_fill_count"}, {27'd0, fill_count}, 32'h0);
    chk({tag, "_empty"}, {31'd0, fifo_Empty}, 32'h1);
    chk({tag, "_aempty"}, {31'd0, almost_empty}, 32'h1);
    chk({tag, "_full"}, {31'd0, fifo_Full}, 32'h0);
    chk({tag, "_afull"}, {31'd0, almost_full}, 32'h0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'h0);
    chk({tag, "_udf"}, {31'd0, underflow}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; err_clr = 1'b0;
    m_ovf = 0; m_udf = 0; m_rvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill with 0x01..0x10; almost_full rises on the 14th write.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 13) chk("afull_at_13", {31'd0, almost_full}, 32'h0);
      if (i == 14) chk("afull_at_14", {31'd0, almost_full}, 32'h1);
    end
    chk("count_full", {27'd0, fill_count}, 32'd16);
    chk("full_flag", {31'd0, fifo_Full}, 32'h1);

    // Drain in order.
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_after_drain", {31'd0, fifo_Empty}, 32'h1);
    chk("no_err_after_drain", {30'd0, overflow, underflow}, 32'h0);

    // Refill, then overflow with 0xAA.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h81 + 8'(i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, overflow}, 32'h1);
    chk("ovf_count", {27'd0, fill_count}, 32'd16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", {31'd0, overflow}, 32'h0);

    // Full with simultaneous read/write for 20 cycles, across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
      chk("full_rw_count", {27'd0, fill_count}, 32'd16);
    end
    chk("full_rw_no_ovf", {31'd0, overflow}, 32'h0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Underflow on an empty read.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", {31'd0, underflow}, 32'h1);
    chk("udf_rd_valid", {31'd0, rd_valid}, 32'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    // Empty with read+write: write lands, read is an underflow.
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("rw_empty_count", {27'd0, fill_count}, 32'd1);
    chk("rw_empty_udf", {31'd0, underflow}, 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Write-to-read latency with 0x3C.
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
    chk("fwft_lat_data", {24'd0, rd_data}, 32'h3C);
    chk("fwft_lat_valid", {31'd0, rd_valid}, 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
`else
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("std_lat_data", {24'd0, rd_data}, 32'h3C);
    chk("std_lat_valid", {31'd0, rd_valid}, 32'h1);
`endif
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset with 7 entries held.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    chk("pre_reset_count", {27'd0, fill_count}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    mq.delete(); exp_q.delete();
    m_ovf = 0; m_udf = 0; m_rvalid = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the same-clock successor to the dual-clock FIFO. Used wherever producer and consumer share one clock, so no gray-code pointer synchronisers are needed. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a compile-time first-word-fall-through read mode.

## Interface
Parameters:
- N, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserted when fill_count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when fill_count ≤ AE_LEVEL

Ports:
- One clock; reset is asynchronous and active-high.
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  N  write data
- rd_en  in  1  read request (read acknowledge in FWFT mode)
- rd_data  out  N  read data
- rd_valid  out  1  rd_data holds a valid word
- fifo_Full  out  1  fill_count == DEPTH
- fifo_Empty  out  1  fill_count == 0
- almost_full  out  1  threshold flag
- almost_empty  out  1  threshold flag
- fill_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write requested while full and not accepted
- underflow  out  1  sticky: read requested while empty
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Write accepted (wr_acc) = wr_en & (~fifo_Full | rd_acc). Read accepted (rd_acc) = rd_en & ~fifo_Empty.
- Pointers wr_ptr/rd_ptr are $clog2(DEPTH) bits, binary, wrap DEPTH-1 → 0 naturally; each advances by 1 on its accept.
- fill_count: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
- All flags are registered, computed from next fill_count, so they are consistent with fill_count in the same cycle.
- Full with simultaneous rd_en & wr_en: both accepted, count stays DEPTH, no overflow.
- Empty with simultaneous rd_en & wr_en: write accepted, read rejected, underflow set, count → 1.
- overflow set when wr_en & ~wr_acc. underflow set when rd_en & fifo_Empty. Both hold until err_clr or rst. If err_clr and a new error occur in the same cycle, the set wins.
- Memory contents are not reset. Only pointers, count, flags and output registers are reset.
- Reset values: rd_data 0, rd_valid 0, fill_count 0, fifo_Empty 1, almost_empty 1, fifo_Full 0, almost_full 0, overflow 0, underflow 0. Reset mid-operation discards all contents immediately (asynchronously).

## Timing
- Standard mode: rd_data is a register loaded with mem[rd_ptr] on rd_acc. It is valid and rd_valid pulses high in cycle t+1 for an accept at t. rd_data holds its value otherwise.
- Write-to-flag latency: 1 cycle. A wr_acc at edge t updates fill_count and flags at t+1.
- A write to an empty FIFO at t can be read by rd_en at t+1. The data appears at t+2 in standard mode.
- Throughput: one write and one read per cycle sustained.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rd_data continuously shows mem[rd_ptr], and rd_valid = ~fifo_Empty.
  - rd_en pops the shown word. The next word is shown the following cycle.
  - A word written to an empty FIFO at t is visible on rd_data with rd_valid=1 at t+1.
  - Reset value of rd_valid is 0.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as above.
- Flag, count and error behaviour are identical in both modes.

## Structure
- Package sync_fifo_pkg holds:
  - default constants (DEF_N=8, DEF_DEPTH=16)
  - function is_pow2 for an elaboration-time check on DEPTH; a non-power-of-two DEPTH is a fatal elaboration error
  - function to compute the count width
- One sub-module, sync_fifo_mem: single-clock simple dual-port RAM with N×DEPTH storage, one write port and an asynchronous read port. The top level owns the read register and all control logic.

## Test plan
N=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2.
- Reset, then write 0x01..0x10 (16 writes) → fill_count 16, fifo_Full=1, almost_full=1 from the 14th write; then read 16 → data 0x01..0x10 in order, fifo_Empty=1, no errors.
- Full, then a 17th write of 0xAA → overflow=1, fill_count stays 16, 0xAA never read; err_clr → overflow=0.
- Full, then wr_en & rd_en together for 20 cycles → count stays 16, no overflow, output order preserved across pointer wrap.
- Empty, then rd_en alone → underflow=1, rd_valid=0. Empty with rd_en & wr_en of 0x55 → count 1, underflow=1, 0x55 readable next cycle.
- Standard mode: write 0x3C at t, rd_en at t+1 → rd_data=0x3C, rd_valid=1 at t+2. FWFT_EN build: same write → rd_data=0x3C, rd_valid=1 at t+1 without rd_en.
- Assert rst asynchronously with 7 entries held → all outputs immediately take their reset values; next write/read round-trips correctly.
